tile_writer: RTL and testbench
==============================

# tile_writer

Writes one feature-map tile from the CNN pipeline into the display BRAM in the packed, raster-ordered word format that the display tiler's tile readers consume. It accepts a valid/ready pixel stream, packs `WORD_BITS/PIX_BITS` pixels per word (pixel 0 in the LSBs), and issues single-cycle BRAM write beats starting at `BASE_ADDR`. The block sits between a CNN layer output and the BRAM write port. One instance is used per tile, or one instance is shared and re-armed per tile by the layer controller.

## Interface
- `BASE_ADDR`, default 12'h000: first BRAM word address of the tile.
- `TILE_W`, default 24: tile width in pixels.
- `TILE_H`, default 24: tile height in pixels.
- `WORD_BITS`, default 256: BRAM word width.
- `PIX_BITS`, default 8: pixel width.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: arm for one tile; pulse.
- `s_valid` in 1: input pixel valid.
- `s_ready` out 1: input pixel ready.
- `s_pixel` in `PIX_BITS`: input pixel, raster order.
- `s_last` in 1: producer marks final pixel of tile.
- `bram_we` out 1: write strobe, one beat per word.
- `bram_addr` out 12: write word address.
- `bram_wdata` out `WORD_BITS`: packed word.
- `busy` out 1: tile in progress.
- `done` out 1: one-cycle pulse with the final write beat.
- `err` out 1: sticky `s_last` mismatch flag. Present only with `TILE_WRITER_LAST_CHECK_EN`.

## Operation
- `PPW = WORD_BITS/PIX_BITS` (32 at defaults).
- `NPIX = TILE_W*TILE_H`.
- `NWORDS = ceil(NPIX/PPW)`.
- Packing is contiguous across rows, with no row alignment. Pixel k of the tile is placed in word `BASE_ADDR + k/PPW`, bits `[(k%PPW)*PIX_BITS +: PIX_BITS]`.
- State machine:
  - IDLE: `s_ready`=0. `start` → FILL, with pixel count, lane index and word address cleared to `BASE_ADDR`.
  - FILL: `s_ready`=1. Each accepted pixel (`s_valid & s_ready`) is shifted into the lane accumulator. When lane reaches PPW-1, or the pixel is pixel NPIX-1, the word is registered to the write port and the accumulator is cleared. Accepting pixel NPIX-1 → DONE.
  - DONE: `s_ready`=0. Final write beat and `done` are presented. → IDLE next cycle.
- In a partial final word, unfilled lanes are zero. Example: 10x10 tile gives 4 words; word 3 carries pixels 96..99 in bits [31:0], with bits [255:32] zero.
- `start` is ignored while `busy`.
- No write occurs for an empty word; the block writes exactly NWORDS beats.
- `s_last` is ignored unless `TILE_WRITER_LAST_CHECK_EN` is defined.
- `busy` = (state != IDLE).

## Timing
- Reset (async assert): state IDLE; `s_ready`, `bram_we`, `busy`, `done`, `err` = 0; `bram_addr` = `BASE_ADDR`; `bram_wdata` = 0; accumulator cleared.
- Write latency: `bram_we` asserts the cycle after the accept that completes a word. It lasts exactly one cycle.
- `bram_addr` increments by 1 after each beat.
- Back-to-back words need no stall. A word-completing accept at cycle N and the next pixel accept at N+1 coexist with the write beat at N+1.
- `s_ready` is deasserted in the cycle after pixel NPIX-1 is accepted, and stays low until the next `start` has moved the block to FILL. The earliest next `s_ready` is two cycles after `done`.
- `done` is coincident with the last `bram_we`.
- Throughput: 1 pixel/cycle sustained.
- `s_valid` gaps are allowed. The lane state holds while `s_valid`=0.
- Reset mid-tile aborts immediately with no further writes. The partially written tile in BRAM is left as is.

## Configuration
- `TILE_WRITER_LAST_CHECK_EN` defined: `err` port exists. `err` sets and stays set until `rst` when either of these occurs:
  - `s_last`=1 is accepted on a pixel other than NPIX-1.
  - `s_last`=0 is accepted on pixel NPIX-1.
- Writes and the state machine are unaffected by `err`.
- `TILE_WRITER_LAST_CHECK_EN` undefined: no `err` port and no check logic; `s_last` is unused.

## Structure
- Shared package `cnn_disp_pkg`:
  - `WORD_BITS`, `PIX_BITS`, `ADDR_BITS`=12.
  - Tile geometry constants: L1 tile 24, L2 tile 10.
  - Tile base addresses 0, 30, 60, 90, 12'h0A0, shared with the tile readers.
  - State enum `tw_state_t` {IDLE, FILL, DONE}.
- Sub-module `pixel_packer`:
  - Lane accumulator with shift-in and lane counter.
  - Word-complete flag and clear input.
  - Parameterised by `WORD_BITS` and `PIX_BITS`.

## Test plan
- Default 24x24, `BASE_ADDR`=0, continuous pixels k&8'hFF → 18 beats at addresses 0..17. Word 0 = bytes 0x00..0x1F, little-endian lanes. `done` arrives with beat 17.
- 10x10, `BASE_ADDR`=12'h0A0 → 4 beats at 0x0A0..0x0A3. Word 3 bits [31:0] = 0x63626160, upper bits 0.
- Random `s_valid` gaps (30% idle) → identical BRAM contents to the continuous case, with one beat per 32 accepts.
- `start` pulsed mid-tile → ignored, with no address reset. `start` in the cycle after `done` → clean second tile at `BASE_ADDR`.
- `rst` asserted after 40 pixels → all outputs zero that cycle, with no further `bram_we`. A subsequent `start` writes the tile correctly.
- With `TILE_WRITER_LAST_CHECK_EN`: `s_last` on pixel 100 of 576 → `err`=1 and stays set. All 18 words are still written.

Source files
------------

// File: rtl/cnn_disp_pkg.sv
// cnn_disp_pkg: constants and types shared by the display-path blocks.
//   WORD_BITS / PIX_BITS / ADDR_BITS : display BRAM word, pixel and address widths
//   L1_TILE / L2_TILE                : square tile edge lengths per CNN layer
//   TILE_BASE_*                      : tile base word addresses, shared with the tile readers
//   tw_state_t                       : tile_writer FSM state
package cnn_disp_pkg;

   localparam int WORD_BITS = 256;
   localparam int PIX_BITS  = 8;
   localparam int ADDR_BITS = 12;

   localparam int L1_TILE = 24;
   localparam int L2_TILE = 10;

   localparam logic [ADDR_BITS-1:0] TILE_BASE_0 = 12'd0;
   localparam logic [ADDR_BITS-1:0] TILE_BASE_1 = 12'd30;
   localparam logic [ADDR_BITS-1:0] TILE_BASE_2 = 12'd60;
   localparam logic [ADDR_BITS-1:0] TILE_BASE_3 = 12'd90;
   localparam logic [ADDR_BITS-1:0] TILE_BASE_4 = 12'h0A0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } tw_state_t;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/tile_writer_pixel_packer.sv
// pixel_packer: packs pixels into a BRAM word, pixel 0 of the word in the LSBs.
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : synchronous clear of accumulator and lane counter (tile start)
//   in_valid      : a pixel is accepted this cycle
//   in_pixel      : the accepted pixel
//   flush         : this pixel closes the word even if lanes remain (tile end)
//   word          : accumulator with the current pixel merged into its lane
//   word_complete : word is final this cycle; caller registers it, packer clears
module pixel_packer import cnn_disp_pkg::*; #(
   parameter int WORD_BITS = 256,
   parameter int PIX_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 in_valid,
   input  logic [PIX_BITS-1:0]  in_pixel,
   input  logic                 flush,
   output logic [WORD_BITS-1:0] word,
   output logic                 word_complete
);

   localparam int PPW    = WORD_BITS / PIX_BITS;
   localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;

   logic [WORD_BITS-1:0] acc;
   logic [LANE_W-1:0]    lane;

   // Lanes above the current one are always zero in acc, so a flushed
   // partial word comes out with its unfilled lanes cleared.
   always_comb begin
      word = acc;
      word[int'(lane)*PIX_BITS +: PIX_BITS] = in_pixel;
      word_complete = in_valid & ((lane == LANE_W'(PPW-1)) | flush);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc  <= '0;
         lane <= '0;
      end else if (clear) begin
         acc  <= '0;
         lane <= '0;
      end else if (in_valid) begin
         if (word_complete) begin
            acc  <= '0;
            lane <= '0;
         end else begin
            acc  <= word;
            lane <= lane + 1'b1;
         end
      end
   end

endmodule

// File: rtl/tile_writer.sv
// tile_writer: writes one raster-ordered feature-map tile into the display BRAM
// as packed words (WORD_BITS/PIX_BITS pixels per word, pixel 0 in the LSBs),
// one write beat per word starting at BASE_ADDR.
// Optional feature macro: TILE_WRITER_LAST_CHECK_EN adds the sticky err output
// that flags an s_last marker disagreeing with the tile geometry.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   start                : arm for one tile (ignored while busy)
//   s_valid/s_ready      : pixel stream handshake
//   s_pixel, s_last      : pixel data, producer end-of-tile marker
//   bram_we/addr/wdata   : single-cycle BRAM write beat
//   busy                 : tile in progress
//   dbg_state            : current FSM state
//   done                 : one-cycle pulse coincident with the final beat
//   err                  : sticky s_last mismatch (macro builds only)
// Handshake: a pixel transfers on every rising clk edge where s_valid and
// s_ready are both high; s_ready depends only on the FSM state, never on
// s_valid, and the producer must hold s_pixel/s_last stable while s_valid
// is high and s_ready is low.
module tile_writer import cnn_disp_pkg::*; #(
   parameter logic [ADDR_BITS-1:0] BASE_ADDR = 12'h000,
   parameter int TILE_W    = 24,
   parameter int TILE_H    = 24,
   parameter int WORD_BITS = 256,
   parameter int PIX_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [PIX_BITS-1:0]  s_pixel,
   input  logic                 s_last,
   output logic                 bram_we,
   output logic [ADDR_BITS-1:0] bram_addr,
   output logic [WORD_BITS-1:0] bram_wdata,
   output logic                 busy,
   output tw_state_t            dbg_state,
   output logic                 done
`ifdef TILE_WRITER_LAST_CHECK_EN
   ,
   output logic                 err
`endif
);

   localparam int NPIX  = TILE_W * TILE_H;
   localparam int CNT_W = $clog2(NPIX + 1);

   tw_state_t            state, state_nxt;
   logic [CNT_W-1:0]     pix_cnt;
   logic                 accept;
   logic                 last_pix;
   logic                 start_tile;
   logic [WORD_BITS-1:0] packed_word;
   logic                 word_complete;

   assign s_ready    = (state == FILL);
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);
   assign dbg_state  = state;
   assign accept     = s_valid & s_ready;
   assign last_pix   = (pix_cnt == CNT_W'(NPIX-1));
   assign start_tile = (state == IDLE) & start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = FILL;
         FILL:    if (accept && last_pix) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   pixel_packer #(
      .WORD_BITS (WORD_BITS),
      .PIX_BITS  (PIX_BITS)
   ) u_packer (
      .clk           (clk),
      .rst           (rst),
      .clear         (start_tile),
      .in_valid      (accept),
      .in_pixel      (s_pixel),
      .flush         (last_pix),
      .word          (packed_word),
      .word_complete (word_complete)
   );

   // bram_addr is the live word pointer: it shows the address during a beat
   // and steps once the beat has gone out, so a beat on the very next cycle
   // already sees the next address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bram_we    <= 1'b0;
         bram_addr  <= BASE_ADDR;
         bram_wdata <= '0;
         pix_cnt    <= '0;
      end else begin
         bram_we <= word_complete;
         if (word_complete) bram_wdata <= packed_word;
         if (start_tile) begin
            pix_cnt   <= '0;
            bram_addr <= BASE_ADDR;
         end else begin
            if (accept)  pix_cnt   <= pix_cnt + 1'b1;
            if (bram_we) bram_addr <= bram_addr + 1'b1;
         end
      end
   end

`ifdef TILE_WRITER_LAST_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                               err <= 1'b0;
      else if (accept && (s_last != last_pix)) err <= 1'b1;
   end
`else
   logic unused_last;
   assign unused_last = s_last;
`endif

endmodule

// File: tb/tb_tile_writer.sv
module tb_tile_writer;
   import cnn_disp_pkg::*;

   localparam int W   = 256;
   localparam int AW  = 12;
   localparam int EW  = 1 + AW + W;
   localparam int PPW = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT A: 24x24 at base 0 ----------------
   logic          a_start = 0, a_valid = 0, a_last = 0;
   logic [7:0]    a_pixel = 0;
   logic          a_ready, a_we, a_busy, a_done;
   logic [AW-1:0] a_addr;
   logic [W-1:0]  a_wdata;
   tw_state_t     a_state;
   // ---------------- DUT B: 10x10 at base 0x0A0 ----------------
   logic          b_start = 0, b_valid = 0, b_last = 0;
   logic [7:0]    b_pixel = 0;
   logic          b_ready, b_we, b_busy, b_done;
   logic [AW-1:0] b_addr;
   logic [W-1:0]  b_wdata;
   tw_state_t     b_state;
`ifdef TILE_WRITER_LAST_CHECK_EN
   logic a_err, b_err;
`endif

   tile_writer u_a (
      .clk(clk), .rst(rst), .start(a_start), .s_valid(a_valid), .s_ready(a_ready),
      .s_pixel(a_pixel), .s_last(a_last), .bram_we(a_we), .bram_addr(a_addr),
      .bram_wdata(a_wdata), .busy(a_busy), .dbg_state(a_state), .done(a_done)
`ifdef TILE_WRITER_LAST_CHECK_EN
      , .err(a_err)
`endif
   );

   tile_writer #(.BASE_ADDR(12'h0A0), .TILE_W(L2_TILE), .TILE_H(L2_TILE)) u_b (
      .clk(clk), .rst(rst), .start(b_start), .s_valid(b_valid), .s_ready(b_ready),
      .s_pixel(b_pixel), .s_last(b_last), .bram_we(b_we), .bram_addr(b_addr),
      .bram_wdata(b_wdata), .busy(b_busy), .dbg_state(b_state), .done(b_done)
`ifdef TILE_WRITER_LAST_CHECK_EN
      , .err(b_err)
`endif
   );

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_a_q[$];
   logic [EW-1:0] exp_b_q[$];
   logic [63:0]   req_got[$];
   logic [63:0]   req_exp[$];
   string         req_name[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   logic [7:0]    pix[L1_TILE*L1_TILE];

   // Point checks from the driver are queued here and compared by the monitor,
   // so the counters have a single writer.
   task automatic post(input string name, input logic [63:0] got, input logic [63:0] exp);
      req_name.push_back(name);
      req_got.push_back(got);
      req_exp.push_back(exp);
   endtask

   // Reference model: pixel k goes to word base + k/32, byte lane k%32.
   task automatic push_model(input bit to_b, input int n, input logic [AW-1:0] base,
                             input int max_words);
      logic [W-1:0] w;
      int nw;
      nw = (n + PPW - 1) / PPW;
      for (int j = 0; j < nw && j < max_words; j++) begin
         w = '0;
         for (int l = 0; l < PPW; l++)
            if (j*PPW + l < n) w[l*8 +: 8] = pix[j*PPW + l];
         if (to_b) exp_b_q.push_back({(j == nw-1), AW'(base + j), w});
         else      exp_a_q.push_back({(j == nw-1), AW'(base + j), w});
      end
   endtask

   always @(negedge clk) begin
      logic [EW-1:0] e;
      logic [63:0]   g, x;
      string         nm;
      while (req_got.size() > 0) begin
         g = req_got.pop_front(); x = req_exp.pop_front(); nm = req_name.pop_front();
         n_cmp++;
         if (g !== x) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, g, x);
         end
      end
      if (a_we) begin
         n_cmp++;
         if (exp_a_q.size() == 0) begin
            n_bad++;
            $display("FAIL a_beat: unexpected beat at addr %h", a_addr);
         end else begin
            e = exp_a_q.pop_front();
            if ({a_done, a_addr, a_wdata} !== e) begin
               n_bad++;
               $display("FAIL a_beat: got done=%b addr=%h data=%h expected done=%b addr=%h data=%h",
                        a_done, a_addr, a_wdata, e[EW-1], e[W +: AW], e[W-1:0]);
            end
         end
      end else if (a_done) begin
         n_cmp++; n_bad++;
         $display("FAIL a_done: got done=1 without beat expected done=0");
      end
      if (b_we) begin
         n_cmp++;
         if (exp_b_q.size() == 0) begin
            n_bad++;
            $display("FAIL b_beat: unexpected beat at addr %h", b_addr);
         end else begin
            e = exp_b_q.pop_front();
            if ({b_done, b_addr, b_wdata} !== e) begin
               n_bad++;
               $display("FAIL b_beat: got done=%b addr=%h data=%h expected done=%b addr=%h data=%h",
                        b_done, b_addr, b_wdata, e[EW-1], e[W +: AW], e[W-1:0]);
            end
         end
      end else if (b_done) begin
         n_cmp++; n_bad++;
         $display("FAIL b_done: got done=1 without beat expected done=0");
      end
   end

   // ---------------- drivers ----------------
   task automatic fill_pix(input bit rnd, input int n);
      for (int k = 0; k < n; k++) pix[k] = rnd ? 8'($urandom) : 8'(k);
   endtask

   task automatic send_a(input int n, input int gap_pct, input int abort_at,
                         input int mid_start_at, input int bad_last_at);
      int t;
      @(posedge clk); #1 a_start = 1;
      @(posedge clk); #1 a_start = 0;
      for (int k = 0; k < n; k++) begin
         if (k == abort_at) begin
            a_valid = 0;
            rst = 1;
            #1;
            post("abort_ready", a_ready, 0);
            post("abort_we", a_we, 0);
            post("abort_busy", a_busy, 0);
            post("abort_done", a_done, 0);
            post("abort_addr", a_addr, 0);
            post("abort_wdata_zero", (a_wdata == '0), 1);
            repeat (2) @(posedge clk);
            #1 rst = 0;
            return;
         end
         while ($urandom_range(99) < gap_pct) begin
            a_valid = 0;
            @(posedge clk); #1;
         end
         a_valid = 1;
         a_pixel = pix[k];
         a_last  = (k == n-1) ^ (k == bad_last_at);
         a_start = (k == mid_start_at);
         t = 0;
         while (!a_ready && t < 50) begin
            @(posedge clk); #1; t++;
         end
         if (t >= 50) begin
            post("a_ready_timeout", 0, 1);
            a_valid = 0; a_start = 0;
            return;
         end
         @(posedge clk); #1;
         a_start = 0;
      end
      a_valid = 0; a_last = 0;
      post("a_ready_in_done", a_ready, 0);
      post("a_done_with_last", a_done, 1);
      post("a_busy_in_done", a_busy, 1);
   endtask

   task automatic send_b(input int n, input int gap_pct);
      int t;
      @(posedge clk); #1 b_start = 1;
      @(posedge clk); #1 b_start = 0;
      for (int k = 0; k < n; k++) begin
         while ($urandom_range(99) < gap_pct) begin
            b_valid = 0;
            @(posedge clk); #1;
         end
         b_valid = 1; b_pixel = pix[k]; b_last = (k == n-1);
         t = 0;
         while (!b_ready && t < 50) begin
            @(posedge clk); #1; t++;
         end
         if (t >= 50) begin
            post("b_ready_timeout", 0, 1);
            b_valid = 0;
            return;
         end
         @(posedge clk); #1;
      end
      b_valid = 0; b_last = 0;
      post("b_ready_in_done", b_ready, 0);
      post("b_done_with_last", b_done, 1);
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while ((exp_a_q.size() > 0 || exp_b_q.size() > 0) && t < 200) begin
         @(posedge clk); #1; t++;
      end
      post(name, exp_a_q.size() + exp_b_q.size(), 0);
      exp_a_q.delete();
      exp_b_q.delete();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(posedge clk);
      #1;
      post("a_ready_rst", a_ready, 0);
      post("a_we_rst", a_we, 0);
      post("a_busy_rst", a_busy, 0);
      post("a_done_rst", a_done, 0);
      post("a_addr_rst", a_addr, 0);
      post("a_wdata_rst_zero", (a_wdata == '0), 1);
      post("a_state_rst", a_state, IDLE);
      post("b_addr_rst", b_addr, 12'h0A0);
      post("b_busy_rst", b_busy, 0);
      post("b_state_rst", b_state, IDLE);
`ifdef TILE_WRITER_LAST_CHECK_EN
      post("a_err_rst", a_err, 0);
      post("b_err_rst", b_err, 0);
`endif
      rst = 0;

      // Continuous 24x24 ramp, then the same data with 30% idle gaps
      // started in the cycle right after done.
      fill_pix(0, 576);
      push_model(0, 576, 12'h000, 99);
      send_a(576, 0, -1, -1, -1);
      push_model(0, 576, 12'h000, 99);
      send_a(576, 30, -1, -1, -1);
      drain("ramp_drained");

      // 10x10 tile at base 0x0A0: word 3 low bytes 0x60..0x63.
      fill_pix(0, 100);
      push_model(1, 100, 12'h0A0, 99);
      send_b(100, 0);
      drain("small_drained");

      // Random data, gaps, and a start pulse mid-tile that must be ignored.
      fill_pix(1, 576);
      push_model(0, 576, 12'h000, 99);
      send_a(576, 20, -1, 50, -1);
      drain("midstart_drained");

      // Reset after 40 pixels: only word 0 was ever written.
      fill_pix(1, 576);
      push_model(0, 576, 12'h000, 1);
      send_a(576, 0, 40, -1, -1);
      drain("abort_drained");
      post("abort_idle_after", a_busy, 0);

      // Clean tile after the abort, plus random small tile with gaps.
      fill_pix(1, 576);
      push_model(0, 576, 12'h000, 99);
      send_a(576, 10, -1, -1, -1);
      drain("post_abort_drained");
      fill_pix(1, 100);
      push_model(1, 100, 12'h0A0, 99);
      send_b(100, 40);
      drain("small_rand_drained");

      // Misplaced s_last on pixel 100: writes unaffected.
      fill_pix(1, 576);
      push_model(0, 576, 12'h000, 99);
      send_a(576, 0, -1, -1, 100);
      drain("bad_last_drained");
`ifdef TILE_WRITER_LAST_CHECK_EN
      post("a_err_set", a_err, 1);
      repeat (5) @(posedge clk);
      #1 post("a_err_sticky", a_err, 1);
      post("b_err_clear", b_err, 0);
`endif

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
